// File: rtl/ps2_direction_receiver.sv
// PS/2 keyboard receiver: deframes scan codes and drives the snake direction and run level.
// Latency: SYNC_STAGES+2 master_clk cycles from stop-bit edge to key_valid; the PS/2 line has no backpressure.
`timescale 1ns/1ps
module ps2_direction_receiver #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       master_clk,
  input  logic       reset,
  input  logic       keyboard_clk,
  input  logic       data,
  output logic [4:0] snake_direction,
  output logic       initialize,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [4:0] DIR_NONE  = 5'b00000;
  localparam logic [4:0] DIR_UP    = 5'b00010;
  localparam logic [4:0] DIR_LEFT  = 5'b00100;
  localparam logic [4:0] DIR_DOWN  = 5'b01000;
  localparam logic [4:0] DIR_RIGHT = 5'b10000;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   dat_s;
  logic [2:0]             bit_cnt, bit_cnt_next;
  logic [7:0]             shift, shift_next;
  logic                   parity_ok, parity_ok_next;
  logic [TW-1:0]          tcnt;
  logic                   timeout;
  logic                   byte_vld, byte_vld_next;
  logic                   frame_err_next;
  logic                   ext, brk;
  logic [4:0]             req;
  logic                   dir_ok;

  // Idle PS/2 bus is high, so the synchronizers come out of reset at 1.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], keyboard_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign dat_s   = dat_sync[SYNC_STAGES-1];
  assign timeout = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (fall || state == IDLE || timeout) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      parity_ok   <= 1'b0;
      byte_vld    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      bit_cnt     <= bit_cnt_next;
      shift       <= shift_next;
      parity_ok   <= parity_ok_next;
      byte_vld    <= byte_vld_next;
      frame_error <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    parity_ok_next = parity_ok;
    byte_vld_next  = 1'b0;
    frame_err_next = 1'b0;
    if (timeout) begin
      state_next     = IDLE;
      frame_err_next = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s) begin
            state_next   = DATA;
            bit_cnt_next = 3'd0;
          end
        end
        DATA: begin
          shift_next   = {dat_s, shift[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          parity_ok_next = ^{shift, dat_s};
          state_next     = STOP;
        end
        STOP: begin
          if (dat_s && parity_ok) byte_vld_next  = 1'b1;
          else                    frame_err_next = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  function automatic logic [4:0] opposite(input logic [4:0] d);
    case (d)
      DIR_UP:    opposite = DIR_DOWN;
      DIR_DOWN:  opposite = DIR_UP;
      DIR_LEFT:  opposite = DIR_RIGHT;
      DIR_RIGHT: opposite = DIR_LEFT;
      default:   opposite = DIR_NONE;
    endcase
  endfunction

  always_comb begin
    req = DIR_NONE;
    case (shift)
      8'h75:   req = DIR_UP;
      8'h6B:   req = DIR_LEFT;
      8'h72:   req = DIR_DOWN;
      8'h74:   req = DIR_RIGHT;
      default: req = DIR_NONE;
    endcase
    dir_ok = initialize && (req != DIR_NONE) && (req != opposite(snake_direction));
  end

  // Prefix bytes only set flags; a byte after F0 is a release and is swallowed.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      snake_direction <= DIR_NONE;
      initialize      <= 1'b0;
      key_valid       <= 1'b0;
      key_code        <= 8'h00;
      key_ext         <= 1'b0;
      ext             <= 1'b0;
      brk             <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (timeout) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_vld) begin
        if (shift == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift == 8'hF0) begin
          brk <= 1'b1;
        end else if (brk) begin
          ext <= 1'b0;
          brk <= 1'b0;
        end else begin
          key_valid <= 1'b1;
          key_code  <= shift;
          key_ext   <= ext;
          ext       <= 1'b0;
          if (ext) begin
            if (dir_ok) snake_direction <= req;
          end else if (shift == 8'h76) begin
            initialize      <= ~initialize;
            snake_direction <= DIR_NONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_direction_receiver.sv
// Directed bench for ps2_direction_receiver with a scoreboard of expected key/error events.
`timescale 1ns/1ps
module tb_ps2_direction_receiver;

  localparam int TO   = 400;
  localparam int HALF = 20;
  localparam int SYNC = 2;

  logic       master_clk = 1'b0;
  logic       reset;
  logic       keyboard_clk;
  logic       data;
  logic [4:0] snake_direction;
  logic       initialize;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       frame_error;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stop_cyc = 0;

  typedef struct {
    logic       err;
    logic [7:0] code;
    logic       ext;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;

  ps2_direction_receiver #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYNC)) dut (
    .master_clk      (master_clk),
    .reset           (reset),
    .keyboard_clk    (keyboard_clk),
    .data            (data),
    .snake_direction (snake_direction),
    .initialize      (initialize),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .key_ext         (key_ext),
    .frame_error     (frame_error)
  );

  always #5 master_clk = ~master_clk;
  always @(posedge master_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge master_clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    data = b;
    tick(HALF);
    keyboard_clk = 1'b0;
    stop_cyc = cyc;
    tick(HALF);
    keyboard_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ flip_par);
    ps2_bit(1'b1);
    tick(10);
  endtask

  task automatic key(input logic [7:0] b, input logic e);
    if (e) send_frame(8'hE0, 1'b0);
    exp_q.push_back('{1'b0, b, e});
    send_frame(b, 1'b0);
  endtask

  // Every key_valid / frame_error cycle must match the oldest expected event.
  always @(negedge master_clk) begin
    if (!reset && (key_valid || frame_error)) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL evt_unexpected observed kv=%b fe=%b expected no event", key_valid, frame_error);
      end
      if (exp_q.size() != 0) begin
        mon_ev = exp_q.pop_front();
        check("evt_frame_error", frame_error, mon_ev.err);
        check("evt_key_valid", key_valid, !mon_ev.err);
        if (!mon_ev.err) begin
          check("evt_key_code", key_code, mon_ev.code);
          check("evt_key_ext", key_ext, mon_ev.ext);
          check("evt_latency", cyc - stop_cyc, SYNC + 2);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    keyboard_clk = 1'b1;
    data = 1'b1;
    tick(3);
    check("rst_dir", snake_direction, 5'b00000);
    check("rst_init", initialize, 1'b0);
    check("rst_kv", key_valid, 1'b0);
    check("rst_code", key_code, 8'h00);
    check("rst_ext", key_ext, 1'b0);
    check("rst_ferr", frame_error, 1'b0);
    reset = 1'b0;
    tick(5);

    key(8'h76, 1'b0);
    check("esc1_init", initialize, 1'b1);
    check("esc1_dir", snake_direction, 5'b00000);
    key(8'h76, 1'b0);
    check("esc2_init", initialize, 1'b0);
    key(8'h74, 1'b1);
    check("held_dir", snake_direction, 5'b00000);
    key(8'h76, 1'b0);
    check("esc3_init", initialize, 1'b1);

    key(8'h74, 1'b1);
    check("right_dir", snake_direction, 5'b10000);
    check("right_ext", key_ext, 1'b1);
    key(8'h6B, 1'b1);
    check("rev_blocked_dir", snake_direction, 5'b10000);
    key(8'h75, 1'b1);
    check("up_dir", snake_direction, 5'b00010);

    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h72, 1'b0);
    check("break_dir", snake_direction, 5'b00010);
    check("break_code", key_code, 8'h75);

    exp_q.push_back('{1'b1, 8'h00, 1'b0});
    send_frame(8'h74, 1'b1);
    check("par_code", key_code, 8'h75);
    check("par_dir", snake_direction, 5'b00010);
    check("par_init", initialize, 1'b1);
    key(8'h1C, 1'b0);
    check("after_par_code", key_code, 8'h1C);
    check("after_par_ext", key_ext, 1'b0);

    send_frame(8'hE0, 1'b0);
    exp_q.push_back('{1'b1, 8'h00, 1'b0});
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    tick(TO + 10);
    check("to_queue", exp_q.size(), 0);
    key(8'h74, 1'b0);
    check("to_ext_cleared", key_ext, 1'b0);
    check("to_dir", snake_direction, 5'b00010);

    key(8'h6B, 1'b1);
    check("left_dir", snake_direction, 5'b00100);
    key(8'h72, 1'b1);
    check("down_dir", snake_direction, 5'b01000);

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    reset = 1'b1;
    #1;
    check("midrst_dir", snake_direction, 5'b00000);
    check("midrst_init", initialize, 1'b0);
    check("midrst_code", key_code, 8'h00);
    tick(5);
    reset = 1'b0;
    tick(5);
    key(8'h76, 1'b0);
    check("post_rst_init", initialize, 1'b1);
    check("post_rst_dir", snake_direction, 5'b00000);

    tick(20);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
